// File: rtl/uart_tx_port.sv
// Port-mapped 8N1 UART transmitter: MCU port writes queue bytes in a small FIFO,
// and a status byte can be read back on the port bus.
module uart_tx_port #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  TX_DATA_ID   = 8'h42,
    parameter logic [7:0]  TX_STATUS_ID = 8'h21
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       TX
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BC_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overrun;

    state_t           state, state_nxt;
    logic [BC_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             tx_nxt;

    logic             wr_sel_c, clr_c, full_c, empty_c, push_c, pop_c, last_c;
    logic [2:0]       cnt_sat_c;
    logic [7:0]       status_c;

    assign wr_sel_c = IO_STRB && (PORT_ID == TX_DATA_ID);
    assign clr_c    = IO_STRB && (PORT_ID == TX_STATUS_ID) && OUT_PORT[3];
    assign full_c   = (count == CNT_W'(FIFO_DEPTH));
    assign empty_c  = (count == '0);
    // A full FIFO still takes a byte when the transmitter frees a slot on the same edge
    assign push_c   = wr_sel_c && (!full_c || pop_c);
    assign last_c   = (bit_cnt == BC_W'(CLKS_PER_BIT - 1));

    // FIFO storage; emptiness is defined by the pointers, so no reset needed
    always_ff @(posedge CLK) begin
        if (push_c) mem[wr_ptr] <= OUT_PORT;
    end

    // FIFO pointers, occupancy and overrun flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_sel_c && !push_c) overrun <= 1'b1;
            else if (clr_c)          overrun <= 1'b0;
        end
    end

    // Transmitter state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            TX      <= 1'b1;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            TX      <= tx_nxt;
        end
    end

    // Transmitter next-state: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        tx_nxt      = TX;
        pop_c       = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!empty_c) begin
                    pop_c       = 1'b1;
                    shift_nxt   = mem[rd_ptr];
                    tx_nxt      = 1'b0;
                    bit_cnt_nxt = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (last_c) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    tx_nxt      = shift[0];
                    shift_nxt   = {1'b0, shift[7:1]};
                    state_nxt   = DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + BC_W'(1);
                end
            end
            DATA: begin
                if (last_c) begin
                    bit_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = shift[0];
                        shift_nxt   = {1'b0, shift[7:1]};
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + BC_W'(1);
                end
            end
            STOP: begin
                if (last_c) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    bit_cnt_nxt = bit_cnt + BC_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status byte and read mux
    always_comb begin
        cnt_sat_c = (32'(count) > 32'd7) ? 3'd7 : 3'(count);
        status_c  = {1'b0, cnt_sat_c, overrun, (state != IDLE), empty_c, full_c};
        IN_PORT   = (PORT_ID == TX_STATUS_ID) ? status_c : 8'h00;
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Randomised scoreboard bench for uart_tx_port: a cycle-level timing model predicts
// FIFO acceptance, status bytes and the start edge of every frame on TX.
module tb_uart_tx_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic [7:0] IN_PORT;
    logic       TX;

    uart_tx_port #(
        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TX_DATA_ID(8'h42), .TX_STATUS_ID(8'h21)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
        .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .TX(TX)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: every accepted byte with its write edge and predicted start edge
    int  acc_wr[$];
    int  acc_st[$];
    int  last_start = -1000;
    logic model_ovr = 1'b0;

    task automatic model_edge(input int e, input logic s, input logic [7:0] id, input logic [7:0] d);
        int cnt;
        bit pop_now;
        int st;
        exp_t x;
        cnt = 0;
        pop_now = 0;
        if (s && id == 8'h42) begin
            foreach (acc_wr[i]) begin
                if (acc_wr[i] < e && acc_st[i] >= e) cnt++;
                if (acc_st[i] == e) pop_now = 1;
            end
            if (cnt < DEPTH || (cnt == DEPTH && pop_now)) begin
                st = (e + 1 > last_start + FRAME + 1) ? e + 1 : last_start + FRAME + 1;
                acc_wr.push_back(e);
                acc_st.push_back(st);
                last_start = st;
                x.data = d;
                x.start = st;
                exp_q.push_back(x);
            end else begin
                model_ovr = 1'b1;
            end
        end else if (s && id == 8'h21 && d[3]) begin
            model_ovr = 1'b0;
        end
    endtask

    function automatic logic [7:0] model_status(input int e);
        int   cnt;
        logic act;
        int   sat;
        cnt = 0;
        act = 1'b0;
        foreach (acc_wr[i]) begin
            if (acc_wr[i] <= e && acc_st[i] > e) cnt++;
            if (acc_st[i] <= e && e < acc_st[i] + FRAME) act = 1'b1;
        end
        sat = (cnt > 7) ? 7 : cnt;
        return {1'b0, 3'(sat), model_ovr, act, (cnt == 0), (cnt == DEPTH)};
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int pos);
        if (pos < CPB) return 1'b0;
        if (pos < 9 * CPB) return d[(pos - CPB) / CPB];
        return 1'b1;
    endfunction

    // One bus cycle: inputs change on the falling edge, model applied for the next rising edge
    task automatic step(input logic s, input logic [7:0] id, input logic [7:0] d);
        @(negedge CLK);
        IO_STRB  = s;
        PORT_ID  = id;
        OUT_PORT = d;
        model_edge(cyc + 1, s, id, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h20, 8'h00);
    endtask

    task automatic check_status(input string nm, input int lit);
        logic [7:0] exp;
        @(negedge CLK);
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h21;
        OUT_PORT = 8'h00;
        #1;
        exp = model_status(cyc);
        tests++;
        if (IN_PORT !== exp) begin
            fails++;
            $display("FAIL %s: status got %02h expected %02h (cycle %0d)", nm, IN_PORT, exp, cyc);
        end
        if (lit >= 0) begin
            tests++;
            if (IN_PORT !== 8'(lit)) begin
                fails++;
                $display("FAIL %s_const: status got %02h expected %02h", nm, IN_PORT, 8'(lit));
            end
        end
    endtask

    task automatic check_val(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET   = 1'b1;
        IO_STRB = 1'b0;
        PORT_ID = 8'h21;
        #1;
        check_val("reset_tx", {7'd0, TX}, 8'h01);
        check_val("reset_status", IN_PORT, 8'h02);
        PORT_ID = 8'h20;
        #1;
        check_val("reset_other_id", IN_PORT, 8'h00);
        acc_wr.delete();
        acc_st.delete();
        exp_q.delete();
        last_start = -1000;
        model_ovr  = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Monitor: detects each start bit, pops the scoreboard and checks the whole 40-cycle frame
    logic       mon_busy = 1'b0;
    logic       mon_err;
    logic [7:0] mon_data;
    int         mon_start;
    int         mon_exp_start;
    initial begin
        exp_t e;
        int pos;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (TX == 1'b0) begin
                    tests++;
                    mon_busy  = 1'b1;
                    mon_start = cyc;
                    if (exp_q.size() == 0) begin
                        mon_data      = 8'h00;
                        mon_exp_start = -1;
                        mon_err       = 1'b1;
                    end else begin
                        e             = exp_q.pop_front();
                        mon_data      = e.data;
                        mon_exp_start = e.start;
                        mon_err       = (e.start != cyc);
                    end
                end
            end else begin
                pos = cyc - mon_start;
                if (TX !== frame_bit(mon_data, pos)) mon_err = 1'b1;
                if (pos == FRAME - 1) begin
                    mon_busy = 1'b0;
                    if (mon_err) begin
                        fails++;
                        $display("FAIL frame: data %02h started at edge %0d, expected start %0d with correct 8N1 bits",
                                 mon_data, mon_start, mon_exp_start);
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
            idle(1);
            n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL drain_timeout: %0d frames still pending", exp_q.size());
        end
        idle(3);
    endtask

    initial begin
        int sb;
        int r;
        // Power-on reset
        repeat (3) @(negedge CLK);
        PORT_ID = 8'h21;
        #1;
        check_val("por_tx", {7'd0, TX}, 8'h01);
        check_val("por_status", IN_PORT, 8'h02);
        PORT_ID = 8'h20;
        #1;
        check_val("por_other_id", IN_PORT, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        idle(2);

        // Reset mid-frame aborts it
        step(1'b1, 8'h42, 8'hA3);
        step(1'b1, 8'h42, 8'h3C);
        idle(10);
        do_reset();
        idle(2);
        check_status("after_reset", 8'h02);
        idle(50);

        // Single byte, status sampled across the frame
        step(1'b1, 8'h42, 8'h55);
        for (int i = 0; i < 45; i++) check_status("single", -1);
        wait_drain();
        check_status("single_done", 8'h02);

        // Overrun: six back-to-back writes
        for (int i = 1; i <= 6; i++) step(1'b1, 8'h42, 8'(i));
        check_status("overrun", 8'h4D);
        step(1'b1, 8'h21, 8'h00);
        check_status("clear_noop", 8'h4D);
        step(1'b1, 8'h21, 8'h08);
        check_status("clear", 8'h45);
        wait_drain();

        // Full FIFO with a pop on the same edge as the fifth write
        step(1'b1, 8'h42, 8'hA1);
        step(1'b1, 8'h42, 8'hB2);
        sb = last_start;
        step(1'b1, 8'h42, 8'hC3);
        step(1'b1, 8'h42, 8'hD4);
        step(1'b1, 8'h42, 8'hE5);
        while (cyc + 1 < sb) idle(1);
        step(1'b1, 8'h42, 8'hF6);
        check_status("full_pop", 8'h45);
        wait_drain();

        // Address decode
        step(1'b1, 8'h40, 8'h11);
        step(1'b1, 8'h43, 8'h22);
        step(1'b0, 8'h42, 8'h33);
        check_status("decode", 8'h02);
        idle(5);
        check_val("decode_tx_idle", {7'd0, TX}, 8'h01);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3, 4: step(1'b1, 8'h42, 8'($urandom));
                5: step(1'b1, 8'h21, 8'($urandom));
                6: step(1'b1, ($urandom_range(0, 1) == 0) ? 8'h40 : 8'h43, 8'($urandom));
                7: step(1'b0, 8'h42, 8'($urandom));
                8: check_status("random", -1);
                default: idle(int'($urandom_range(1, 60)));
            endcase
        end
        wait_drain();
        check_status("final", -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
